// File: rtl/lane_accumulator.sv
// rtl/lane_accumulator.sv - lane-packed modular accumulation buffer with RMW forwarding and clear engine
module lane_accumulator #(
    parameter int ADDR_WIDTH = 9,
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 16,
    parameter int MOD_BITS   = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          wr_en,
    input  logic [1:0]                    wr_op,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [LANES*LANE_WIDTH-1:0]   wr_data,
    output logic                          wr_ready,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic                          rd_ready,
    output logic                          rd_valid,
    output logic [LANES*LANE_WIDTH-1:0]   rd_data,
    input  logic                          clr_start,
    output logic                          clr_busy,
    output logic                          clr_done
);
    localparam int DATA_WIDTH = LANES * LANE_WIDTH;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;
    localparam logic [LANE_WIDTH-1:0] LANE_MASK = {LANE_WIDTH{1'b1}} >> (LANE_WIDTH - MOD_BITS);

    typedef enum logic [1:0] {IDLE, DRAIN, SWEEP, DONE} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   sweep_cnt;
    logic                    sweep_we;

    logic                    wr_acc, wr_addsub;
    logic                    s1_valid, s2_valid, s3_valid;
    logic [1:0]              s1_op;
    logic [ADDR_WIDTH-1:0]   s1_addr, s2_addr, s3_addr, rd_addr_q;
    logic [DATA_WIDTH-1:0]   s1_data, s2_data, s3_data;
    logic [DATA_WIDTH-1:0]   s1_old, s1_result, rd_fwd, rd_hold;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_q;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr, ram_raddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;

    function automatic logic [DATA_WIDTH-1:0] lane_math(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] opnd,
        input logic                  sub
    );
        logic [DATA_WIDTH-1:0] res;
        logic [LANE_WIDTH-1:0] a, b, r;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            a = old[i*LANE_WIDTH +: LANE_WIDTH];
            b = opnd[i*LANE_WIDTH +: LANE_WIDTH];
            r = sub ? (a - b) : (a + b);
            res[i*LANE_WIDTH +: LANE_WIDTH] = r & LANE_MASK;
        end
        return res;
    endfunction

    assign clr_busy  = (state != IDLE);
    assign wr_ready  = !clr_busy && (state == IDLE);
    assign wr_addsub = (wr_op == OP_ADD) || (wr_op == OP_SUB);
    assign rd_ready  = !(wr_en && wr_addsub) && !clr_busy;
    assign wr_acc    = wr_en && wr_ready;

    // Add/sub owns the shared read port in its accept cycle; otherwise it serves external reads.
    assign ram_raddr = (wr_acc && wr_addsub) ? wr_addr : rd_addr;
    assign ram_we    = sweep_we || s2_valid;
    assign ram_waddr = sweep_we ? sweep_cnt : s2_addr;
    assign ram_wdata = sweep_we ? '0 : s2_data;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_q <= mem[ram_raddr];
    end

    // s2 writes this edge and s3 wrote on the edge that captured ram_q, so neither is trusted from RAM.
    always_comb begin
        s1_old = ram_q;
        if (s2_valid && s2_addr == s1_addr) begin
            s1_old = s2_data;
        end else if (s3_valid && s3_addr == s1_addr) begin
            s1_old = s3_data;
        end
    end

    always_comb begin
        rd_fwd = ram_q;
        if (s2_valid && s2_addr == rd_addr_q) begin
            rd_fwd = s2_data;
        end else if (s3_valid && s3_addr == rd_addr_q) begin
            rd_fwd = s3_data;
        end
    end

    assign s1_result = (s1_op == OP_WRITE) ? s1_data : lane_math(s1_old, s1_data, s1_op == OP_SUB);
    assign rd_data   = rd_valid ? rd_fwd : rd_hold;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid  <= 1'b0;
            s1_op     <= OP_NOP;
            s1_addr   <= '0;
            s1_data   <= '0;
            s2_valid  <= 1'b0;
            s2_addr   <= '0;
            s2_data   <= '0;
            s3_valid  <= 1'b0;
            s3_addr   <= '0;
            s3_data   <= '0;
            rd_valid  <= 1'b0;
            rd_addr_q <= '0;
            rd_hold   <= '0;
        end else begin
            s1_valid  <= wr_acc && (wr_op != OP_NOP);
            s1_op     <= wr_op;
            s1_addr   <= wr_addr;
            s1_data   <= wr_data;
            s2_valid  <= s1_valid;
            s2_addr   <= s1_addr;
            s2_data   <= s1_result;
            s3_valid  <= s2_valid;
            s3_addr   <= s2_addr;
            s3_data   <= s2_data;
            rd_valid  <= rd_en && rd_ready;
            rd_addr_q <= rd_addr;
            if (rd_valid) begin
                rd_hold <= rd_fwd;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= (state == SWEEP) ? sweep_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_start) state_nxt = DRAIN;
            DRAIN:   if (!s1_valid && !s2_valid) state_nxt = SWEEP;
            SWEEP:   if (sweep_cnt == {ADDR_WIDTH{1'b1}}) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sweep_we = 1'b0;
        clr_done = 1'b0;
        case (state)
            SWEEP:   sweep_we = 1'b1;
            DONE:    clr_done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lane_accumulator.sv
// tb/tb_lane_accumulator.sv - randomized, model-checked bench for lane_accumulator
module tb_lane_accumulator;
    localparam int AW = 9;
    localparam int LN = 4;
    localparam int LW = 16;
    localparam int MB = 16;
    localparam int DW = LN * LW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic [1:0]    wr_op;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] model [1 << AW];

    lane_accumulator #(.ADDR_WIDTH(AW), .LANES(LN), .LANE_WIDTH(LW), .MOD_BITS(MB)) dut (
        .clk(clk), .rstn(rstn),
        .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: each lane is an integer reduced modulo q = 2^MB.
    function automatic logic [DW-1:0] apply_op(input logic [DW-1:0] old, input logic [1:0] op, input logic [DW-1:0] d);
        logic [DW-1:0] res;
        longint q, o, b, r;
        q = longint'(1) << MB;
        if (op == 2'b00) return d;
        if (op == 2'b11) return old;
        res = '0;
        for (int i = 0; i < LN; i++) begin
            o = longint'(old[i*LW +: LW]);
            b = longint'(d[i*LW +: LW]);
            r = (op == 2'b01) ? (o + b) % q : (((o - b) % q) + q) % q;
            res[i*LW +: LW] = LW'(r);
        end
        return res;
    endfunction

    task automatic step(input logic we, input logic [1:0] op, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra,
                        output logic rr_obs, output logic exp_rr, output logic [DW-1:0] exp_data,
                        output logic got_valid, output logic [DW-1:0] got_data);
        wr_en = we; wr_op = op; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        #1;
        rr_obs   = rd_ready;
        exp_rr   = !(we && (op == 2'b01 || op == 2'b10));
        exp_data = model[ra];
        if (we) model[wa] = apply_op(model[wa], op, wd);
        @(posedge clk); #1;
        got_valid = rd_valid;
        got_data  = rd_data;
        wr_en = 1'b0; rd_en = 1'b0; wr_op = 2'b11;
    endtask

    task automatic do_clear(output int busy_cycles, output int done_pulses, output int done_at,
                            output logic blocked, output logic timeout);
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start   = 1'b0;
        blocked     = !wr_ready && !rd_ready;
        busy_cycles = 0; done_pulses = 0; done_at = 0; timeout = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (clr_busy) busy_cycles++;
            if (clr_done) begin done_pulses++; done_at = busy_cycles; end
            if (!clr_busy) begin timeout = 1'b0; break; end
            @(posedge clk); #1;
        end
        for (int a = 0; a < (1 << AW); a++) model[a] = '0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({wr_ready, rd_ready, rd_valid, clr_busy, clr_done} !== 5'b11000 || rd_data !== '0) begin
            n_err++;
            $display("FAIL reset_state: got wr_ready=%b rd_ready=%b rd_valid=%b clr_busy=%b clr_done=%b rd_data=%h, want 1 1 0 0 0 0",
                     wr_ready, rd_ready, rd_valid, clr_busy, clr_done, rd_data);
        end
    endtask

    task automatic test_clear();
        int bc, dp, da; logic blk, to;
        logic rr, er, gv; logic [DW-1:0] ed, gd;
        do_clear(bc, dp, da, blk, to);
        n_cmp++;
        if (to || bc != 514 || dp != 1 || da != 514 || !blk) begin
            n_err++;
            $display("FAIL clear_sequence: got busy=%0d done_pulses=%0d done_at=%0d blocked=%b timeout=%b, want 514 1 514 1 0",
                     bc, dp, da, blk, to);
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 2'b11, '0, '0, 1'b1, (k == 0) ? 9'h000 : 9'h1FF, rr, er, ed, gv, gd);
            n_cmp++;
            if (gv !== 1'b1 || gd !== 64'd0) begin
                n_err++;
                $display("FAIL clear_read_%0d: got valid=%b data=%h, want 1 0", k, gv, gd);
            end
        end
    endtask

    task automatic test_lane_wrap();
        logic rr, er, gv; logic [DW-1:0] ed, gd;
        step(1'b1, 2'b00, 9'h010, 64'h0004_0003_0002_0001, 1'b0, '0, rr, er, ed, gv, gd);
        step(1'b1, 2'b01, 9'h010, 64'h0001_0001_0001_FFFF, 1'b0, '0, rr, er, ed, gv, gd);
        step(1'b0, 2'b11, '0, '0, 1'b1, 9'h010, rr, er, ed, gv, gd);
        n_cmp++;
        if (gv !== 1'b1 || gd !== 64'h0005_0004_0003_0000) begin
            n_err++;
            $display("FAIL lane_wrap: got valid=%b data=%h, want 1 0005000400030000", gv, gd);
        end
    endtask

    task automatic test_back_to_back();
        logic rr, er, gv; logic [DW-1:0] ed, gd;
        for (int k = 0; k < 4; k++) step(1'b1, 2'b01, 9'h050, 64'd10, 1'b0, '0, rr, er, ed, gv, gd);
        step(1'b0, 2'b11, '0, '0, 1'b1, 9'h050, rr, er, ed, gv, gd);
        n_cmp++;
        if (gv !== 1'b1 || gd !== 64'd40) begin
            n_err++;
            $display("FAIL b2b_add: got valid=%b data=%0d, want 1 40", gv, gd);
        end
        step(1'b1, 2'b00, 9'h050, 64'd0, 1'b0, '0, rr, er, ed, gv, gd);
        for (int k = 0; k < 3; k++) step(1'b1, 2'b01, 9'h050, 64'd10, 1'b0, '0, rr, er, ed, gv, gd);
        step(1'b1, 2'b01, 9'h050, 64'd10, 1'b1, 9'h050, rr, er, ed, gv, gd);
        n_cmp++;
        if (rr !== 1'b0 || gv !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_conflict: got rd_ready=%b rd_valid=%b, want 0 0", rr, gv);
        end
        step(1'b0, 2'b11, '0, '0, 1'b1, 9'h050, rr, er, ed, gv, gd);
        n_cmp++;
        if (gv !== 1'b1 || gd !== 64'd40) begin
            n_err++;
            $display("FAIL b2b_retry: got valid=%b data=%0d, want 1 40", gv, gd);
        end
    endtask

    task automatic test_sub_wrap();
        logic rr, er, gv; logic [DW-1:0] ed, gd, want;
        want = (64'd1 << MB) - 64'd1;
        step(1'b1, 2'b10, 9'h020, 64'd1, 1'b0, '0, rr, er, ed, gv, gd);
        step(1'b0, 2'b11, '0, '0, 1'b1, 9'h020, rr, er, ed, gv, gd);
        n_cmp++;
        if (gv !== 1'b1 || gd !== want) begin
            n_err++;
            $display("FAIL sub_wrap: got valid=%b data=%h, want 1 %h", gv, gd, want);
        end
    endtask

    task automatic test_same_cycle();
        logic rr, er, gv; logic [DW-1:0] ed, gd;
        step(1'b1, 2'b00, 9'h080, 64'd5, 1'b0, '0, rr, er, ed, gv, gd);
        step(1'b1, 2'b00, 9'h080, 64'hDEAD_BEEF, 1'b1, 9'h080, rr, er, ed, gv, gd);
        n_cmp++;
        if (rr !== 1'b1 || gv !== 1'b1 || gd !== 64'd5) begin
            n_err++;
            $display("FAIL same_cycle_old: got rd_ready=%b valid=%b data=%h, want 1 1 5", rr, gv, gd);
        end
        step(1'b0, 2'b11, '0, '0, 1'b1, 9'h080, rr, er, ed, gv, gd);
        n_cmp++;
        if (gv !== 1'b1 || gd !== 64'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL same_cycle_new: got valid=%b data=%h, want 1 deadbeef", gv, gd);
        end
    endtask

    task automatic test_random();
        logic rr, er, gv, we, re; logic [DW-1:0] ed, gd, wd; logic [1:0] op; logic [AW-1:0] wa, ra;
        logic [DW-1:0] held;
        held = rd_data;
        for (int k = 0; k < 400; k++) begin
            we = ($urandom_range(0, 9) < 7);
            re = ($urandom_range(0, 1) == 1);
            op = 2'($urandom_range(0, 3));
            wa = AW'($urandom_range(0, 7));
            ra = AW'($urandom_range(0, 7));
            wd = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) wd = wd & 64'h0003_0003_0003_0003;
            step(we, op, wa, wd, re, ra, rr, er, ed, gv, gd);
            n_cmp++;
            if (rr !== er || gv !== (re && er)) begin
                n_err++;
                $display("FAIL rand_handshake[%0d]: got rd_ready=%b rd_valid=%b, want %b %b", k, rr, gv, er, re && er);
            end
            n_cmp++;
            if ((re && er) ? (gd !== ed) : (gd !== held)) begin
                n_err++;
                $display("FAIL rand_data[%0d]: got %h, want %h", k, gd, (re && er) ? ed : held);
            end
            if (re && er) held = ed;
        end
    endtask

    task automatic test_reset_mid_sweep();
        int bc, dp, da; logic blk, to;
        logic rr, er, gv; logic [DW-1:0] ed, gd;
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        repeat (101) begin @(posedge clk); #1; end
        #2 rstn = 1'b0;
        #1;
        test_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        do_clear(bc, dp, da, blk, to);
        n_cmp++;
        if (to || dp != 1 || bc != 514) begin
            n_err++;
            $display("FAIL reclear: got busy=%0d done_pulses=%0d timeout=%b, want 514 1 0", bc, dp, to);
        end
        step(1'b0, 2'b11, '0, '0, 1'b1, 9'h1FF, rr, er, ed, gv, gd);
        n_cmp++;
        if (gv !== 1'b1 || gd !== 64'd0) begin
            n_err++;
            $display("FAIL reclear_read: got valid=%b data=%h, want 1 0", gv, gd);
        end
    endtask

    initial begin
        rstn = 1'b0; wr_en = 1'b0; wr_op = 2'b11; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rstn = 1'b1;
        @(posedge clk); #1;
        test_clear();
        test_lane_wrap();
        test_back_to_back();
        test_sub_wrap();
        test_same_cycle();
        test_random();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
